// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int NUM_DIGITS = 4;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}, indexed by hex nibble.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decode.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup of the cathode pattern for the selected nibble.
  always_comb begin
    seg_n = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Each digit slot is preceded
// by an all-off slot to avoid ghosting; the scan advances on rising edges of
// scan_clk, which is sampled as ordinary data in the clock_in domain.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  scan_clk,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  logic                  scan_clk_q;
  logic                  step_s;
  scan_state_e           state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;
  logic [3:0]            cur_nib_s;
  logic [6:0]            dec_seg_s;
  logic                  lz_s;

  assign step_s = scan_clk & ~scan_clk_q;

  // Scan state machine: BLANK/DRIVE alternation, digit index and frame shadow load.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    wrap_d       = 1'b0;
    if (step_s) begin
      case (state_q)
        ST_BLANK: begin
          state_d = ST_DRIVE;
          if (idx_q == 2'd0) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_mask;
          end else begin
            shadow_val_d = shadow_val_q;
            shadow_dp_d  = shadow_dp_q;
          end
        end
        ST_DRIVE: begin
          state_d = ST_BLANK;
          idx_d   = idx_q + 2'd1;
          wrap_d  = (idx_q == 2'd3);
        end
        default: begin
          state_d = ST_BLANK;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Select the shadow nibble and leading-zero status of the current digit.
  always_comb begin
    cur_nib_s = 4'h0;
    lz_s      = 1'b0;
    case (idx_q)
      2'd0: begin
        cur_nib_s = shadow_val_q[3:0];
        lz_s      = 1'b0;
      end
      2'd1: begin
        cur_nib_s = shadow_val_q[7:4];
        lz_s      = (shadow_val_q[15:4] == 12'h000);
      end
      2'd2: begin
        cur_nib_s = shadow_val_q[11:8];
        lz_s      = (shadow_val_q[15:8] == 8'h00);
      end
      2'd3: begin
        cur_nib_s = shadow_val_q[15:12];
        lz_s      = (shadow_val_q[15:12] == 4'h0);
      end
      default: begin
        cur_nib_s = 4'h0;
        lz_s      = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .nibble (cur_nib_s),
    .seg_n  (dec_seg_s)
  );

  // Output pattern for the current state; blanked digits look exactly like BLANK.
  always_comb begin
    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    frame_done_d = wrap_q;
    if ((state_q == ST_DRIVE) && !(LZ_BLANK && lz_s)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg_s;
      dp_d  = ~shadow_dp_q[idx_q];
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      scan_clk_q   <= 1'b1;
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      wrap_q       <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      scan_clk_q   <= scan_clk;
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: LZ_BLANK, 1, when 1 leading-zero digits are blanked; when 0 all four digits are always lit.
REQ-002 Port: clock_in  input  1  FPGA system clock; sole clock of the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clock_in.
REQ-004 Port: scan_clk  input  1  divided square wave from the clock divider; treated as data in the clock_in domain, never used as a clock.
REQ-005 Port: value  input  16  four hex nibbles; value[3:0] is digit 0 (rightmost).
REQ-006 Port: dp_mask  input  4  decimal-point request per digit; bit i maps to digit i.
REQ-007 Port: an  output  4  digit anodes, active-low; bit i maps to digit i.
REQ-008 Port: seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 Port: dp  output  1  decimal-point cathode, active-low.
REQ-010 Port: frame_done  output  1  one-clock pulse at the end of each full 4-digit scan.

Function
REQ-011 The block SHALL register scan_clk into scan_clk_q every clock; step = scan_clk & ~scan_clk_q.
REQ-012 The state machine SHALL have two states, BLANK and DRIVE, plus a 2-bit digit index that wraps 3->0.
REQ-013 A step in BLANK SHALL move to DRIVE with the digit index unchanged.
REQ-014 A step in DRIVE SHALL move to BLANK and increment the digit index modulo 4.
REQ-015 Without a step, the state and digit index SHALL hold; a stuck scan_clk freezes the scan.
REQ-016 On the BLANK->DRIVE transition with digit index 0, value and dp_mask SHALL be copied into shadow registers; the shadows SHALL not change at any other time.
REQ-017 Changes to value or dp_mask mid-frame SHALL be invisible until the next shadow load.
REQ-018 an, seg and dp SHALL be registered and SHALL reflect the state one clock after the state update.
REQ-019 In BLANK, an SHALL be 4'b1111, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-020 In DRIVE for digit i, an[i] SHALL be 0 and the other an bits 1; seg SHALL be the decoded shadow nibble i; dp SHALL be ~shadow_dp[i].
REQ-021 Decode SHALL be standard hex, for example: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110.
REQ-022 When LZ_BLANK=1, digit i>=1 SHALL be blanked (driven exactly as in BLANK) if shadow nibbles i..3 are all zero.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 frame_done SHALL be registered and SHALL assert for exactly one clock, coincident with the output update of the DRIVE(digit 3)->BLANK transition.
REQ-025 Two steps SHALL be at least 2 clocks apart by construction; no step SHALL be lost when scan_clk toggles every clock_in cycle.

Reset
REQ-026 On reset, the block SHALL set: state to BLANK, digit index to 0, scan_clk_q to 1 (no spurious step if scan_clk is high at release), shadows to 0, an to 1111, seg to 1111111, dp to 1, frame_done to 0.
REQ-027 Reset asserted mid-frame SHALL take effect at the next clock edge; no partial-digit output SHALL persist.

Structure
REQ-028 A shared package seg7_pkg SHALL hold the state enum, the NUM_DIGITS=4 constant and the 16-entry hex-to-segment table.
REQ-029 The nibble decode SHALL be a separate combinational sub-module, seg7_decode (4-bit in, 7-bit out).
REQ-030 scan_clk SHALL connect directly to the clock divider output, with no extra synchronizer stage.

Verification
REQ-031 value=16'h12AF, LZ_BLANK=1, eight scan_clk rising edges from reset -> digits 0..3 show F, A, 2, 1 with the matching an, each preceded by an all-off BLANK slot; frame_done pulses once.
REQ-032 value=16'h0005, LZ_BLANK=1 -> digit 0 shows 0010010 and digits 1-3 stay fully off; with LZ_BLANK=0, digits 1-3 show 1000000.
REQ-033 value changes from 16'h1111 to 16'h2222 while digit 2 is DRIVEn -> digits 2-3 of the current frame still show 1; the next frame shows 2 on all digits.
REQ-034 scan_clk held high through reset release -> no state change until scan_clk falls and rises again.
REQ-035 Reset asserted during DRIVE of digit 1 -> the next clock shows an=1111, seg=1111111, frame_done=0, and the scan restarts at digit 0.
REQ-036 dp_mask=4'b0100, scan_clk toggling every clock -> dp=0 only during DRIVE of digit 2, every frame, with no skipped digits.
